// File: rtl/ccsds123_axis_out_pkg.sv
// ----------------------------------------------------------------------------
// ccsds123_axis_out_pkg
// Shared defaults for the compressed-stream output adapter, so the compressor
// top and the adapter agree on the word and counter widths, plus the small
// control bundle used by the adapter to steer its FIFO.
// ----------------------------------------------------------------------------
package ccsds123_axis_out_pkg;

   // Compressed word width; must match the core's output bus width.
   localparam int BUS_WIDTH_DEF = 64;
   // Width of the per-frame word counter.
   localparam int CNT_W_DEF     = 32;
   // log2 of the output FIFO depth.
   localparam int DEPTH_LOG_DEF = 4;
   // almost_full asserts when free entries <= this margin.
   localparam int AF_MARGIN_DEF = 4;

   // Per-cycle FIFO steering decisions made by the adapter.
   typedef struct packed {
      logic push;   // incoming word is written into the FIFO
      logic pop;    // output word is accepted downstream
      logic drop;   // incoming word is discarded because the FIFO is full
   } fifo_ctl_t;

endpackage

// File: rtl/ccsds123_sync_fifo.sv
// ----------------------------------------------------------------------------
// ccsds123_sync_fifo
// Single-clock FIFO with a first-word-fall-through registered output stage.
// Each entry carries a WIDTH-bit payload plus a one-bit tag (used as a
// frame-end marker by stream blocks). The tag of the newest entry can be set
// after the fact, which lets a producer terminate a frame whose final word had
// to be dropped.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push_i         write push_data_i / push_tag_i (caller guarantees room,
//                  or a simultaneous pop when full)
//   tag_tail_i     set the tag of the most recently written entry
//   pop_i          consume the word currently presented on out_*
//   full_o         all 2**DEPTH_LOG entries are occupied
//   count_o        occupancy, including the word shown on the output stage
//   out_valid_o    registered valid of the presented word
//   out_data_o     registered payload of the presented word
//   out_tag_o      registered tag of the presented word
// ----------------------------------------------------------------------------
module ccsds123_sync_fifo
   import ccsds123_axis_out_pkg::*;
#(
   parameter int WIDTH     = BUS_WIDTH_DEF,
   parameter int DEPTH_LOG = DEPTH_LOG_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push_i,
   input  logic [WIDTH-1:0]     push_data_i,
   input  logic                 push_tag_i,
   input  logic                 tag_tail_i,
   input  logic                 pop_i,
   output logic                 full_o,
   output logic [DEPTH_LOG:0]   count_o,
   output logic                 out_valid_o,
   output logic [WIDTH-1:0]     out_data_o,
   output logic                 out_tag_o
);

   localparam int                 DEPTH   = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] DEPTH_C = (DEPTH_LOG + 1)'(DEPTH);

   // Payload storage: written on push, read through the output register only.
   logic [WIDTH-1:0]     mem_q [DEPTH];
   // Tag bits live in flops so the tail entry can be modified in place.
   logic                 tag_q [DEPTH];

   logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG:0]   count_q, count_d;
   logic [DEPTH_LOG:0]   avail;
   logic [DEPTH_LOG-1:0] tail_idx;
   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     out_data_q, out_data_d;
   logic                 out_tag_q, out_tag_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG'(push_i);
      rd_ptr_d = rd_ptr_q + DEPTH_LOG'(pop_i);
      count_d  = count_q + (DEPTH_LOG + 1)'(push_i) - (DEPTH_LOG + 1)'(pop_i);
      tail_idx = wr_ptr_q - DEPTH_LOG'(1);

      // Words already resident in memory before this edge that survive the
      // pop. A word written on this same edge is not yet readable, which is
      // what gives the one-cycle fall-through latency.
      avail = count_q - (DEPTH_LOG + 1)'(pop_i);

      out_valid_d = (avail != '0);
      out_data_d  = out_data_q;
      out_tag_d   = 1'b0;
      if (out_valid_d) begin
         // Reloading the same head while stalled keeps tdata stable.
         out_data_d = mem_q[rd_ptr_d];
         // Forward a tail-tag update landing on the entry being loaded.
         out_tag_d  = tag_q[rd_ptr_d] | (tag_tail_i && (rd_ptr_d == tail_idx));
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         tag_q[wr_ptr_q] <= push_tag_i;
      end
      if (tag_tail_i) begin
         tag_q[tail_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_tag_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign full_o      = (count_q == DEPTH_C);
   assign count_o     = count_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_tag_o   = out_tag_q;

endmodule

// File: rtl/ccsds123_axis_out.sv
// ----------------------------------------------------------------------------
// ccsds123_axis_out
// Output adapter for the compressed bitstream. Words from the core arrive
// without backpressure and are buffered in a FIFO, then re-emitted as an
// AXI4-Stream master. Also produces an upstream throttle hint, a sticky
// overflow flag and per-frame word counts.
//
// Ports:
//   clk, aresetn     clock, asynchronous active-low reset
//   in_data/valid/last   core output word, qualifier and end-of-image marker
//   almost_full      registered: free entries after this cycle <= AF_MARGIN
//   m_axis_*         AXI4-Stream master (tdata, tvalid, tready, tlast)
//   overflow         sticky: a word was dropped because the FIFO was full
//   frame_done       one-cycle pulse after the tlast word is accepted
//   frame_words      length of the last completed frame, tlast word included
// ----------------------------------------------------------------------------
module ccsds123_axis_out
   import ccsds123_axis_out_pkg::*;
#(
   parameter int BUS_WIDTH = BUS_WIDTH_DEF,
   parameter int DEPTH_LOG = DEPTH_LOG_DEF,
   parameter int AF_MARGIN = AF_MARGIN_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic [BUS_WIDTH-1:0] in_data,
   input  logic                 in_valid,
   input  logic                 in_last,
   output logic                 almost_full,
   output logic [BUS_WIDTH-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic                 overflow,
   output logic                 frame_done,
   output logic [CNT_W-1:0]     frame_words
);

   localparam logic [DEPTH_LOG:0] DEPTH_C = (DEPTH_LOG + 1)'(1 << DEPTH_LOG);
   localparam logic [DEPTH_LOG:0] AF_C    = (DEPTH_LOG + 1)'(AF_MARGIN);

   fifo_ctl_t            ctl;
   logic                 tag_tail;
   logic                 fifo_full;
   logic [DEPTH_LOG:0]   fifo_count;
   logic [DEPTH_LOG:0]   count_next;
   logic [DEPTH_LOG:0]   free_next;

   logic                 af_q, af_d;
   logic                 overflow_q, overflow_d;
   logic                 frame_done_q, frame_done_d;
   logic [CNT_W-1:0]     frame_words_q, frame_words_d;
   logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]     word_inc;

   // A full FIFO still accepts a word when the head leaves on the same edge.
   always_comb begin
      ctl.pop  = m_axis_tvalid && m_axis_tready;
      ctl.push = in_valid && (!fifo_full || ctl.pop);
      ctl.drop = in_valid && fifo_full && !ctl.pop;
   end

   // When the final word of an image is lost, mark the newest buffered word
   // as the frame end so downstream still sees a terminated frame.
   assign tag_tail = ctl.drop && in_last;

   ccsds123_sync_fifo #(
      .WIDTH     (BUS_WIDTH),
      .DEPTH_LOG (DEPTH_LOG)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (aresetn),
      .push_i      (ctl.push),
      .push_data_i (in_data),
      .push_tag_i  (in_last),
      .tag_tail_i  (tag_tail),
      .pop_i       (ctl.pop),
      .full_o      (fifo_full),
      .count_o     (fifo_count),
      .out_valid_o (m_axis_tvalid),
      .out_data_o  (m_axis_tdata),
      .out_tag_o   (m_axis_tlast)
   );

   always_comb begin
      count_next = fifo_count + (DEPTH_LOG + 1)'(ctl.push) - (DEPTH_LOG + 1)'(ctl.pop);
      free_next  = DEPTH_C - count_next;
      af_d       = (free_next <= AF_C);

      overflow_d = overflow_q || ctl.drop;

      // Saturating increment; a frame longer than the counter range reports
      // the maximum value rather than wrapping.
      word_inc = (word_cnt_q == {CNT_W{1'b1}}) ? word_cnt_q : word_cnt_q + CNT_W'(1);

      word_cnt_d    = word_cnt_q;
      frame_words_d = frame_words_q;
      frame_done_d  = 1'b0;
      if (ctl.pop) begin
         if (m_axis_tlast) begin
            frame_words_d = word_inc;
            word_cnt_d    = '0;
            frame_done_d  = 1'b1;
         end else begin
            word_cnt_d = word_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         af_q          <= 1'b0;
         overflow_q    <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_words_q <= '0;
         word_cnt_q    <= '0;
      end else begin
         af_q          <= af_d;
         overflow_q    <= overflow_d;
         frame_done_q  <= frame_done_d;
         frame_words_q <= frame_words_d;
         word_cnt_q    <= word_cnt_d;
      end
   end

   assign almost_full = af_q;
   assign overflow    = overflow_q;
   assign frame_done  = frame_done_q;
   assign frame_words = frame_words_q;

endmodule

// File: tb/tb_ccsds123_axis_out.sv
// ----------------------------------------------------------------------------
// tb_ccsds123_axis_out
// Directed bench for the compressed-stream output adapter. Stimulus pushes
// expected beats and frame lengths into queues; a monitor pops and compares
// them as the DUT hands words downstream.
// ----------------------------------------------------------------------------
module tb_ccsds123_axis_out;

   localparam int BW = 64;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          aresetn;
   logic [BW-1:0] in_data;
   logic          in_valid;
   logic          in_last;
   logic          almost_full;
   logic [BW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic          overflow;
   logic          frame_done;
   logic [CW-1:0] frame_words;

   always #5 clk = ~clk;

   ccsds123_axis_out #(
      .BUS_WIDTH (BW),
      .DEPTH_LOG (4),
      .AF_MARGIN (4),
      .CNT_W     (CW)
   ) dut (
      .clk           (clk),
      .aresetn       (aresetn),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_last       (in_last),
      .almost_full   (almost_full),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .overflow      (overflow),
      .frame_done    (frame_done),
      .frame_words   (frame_words)
   );

   typedef struct packed {
      logic          last;
      logic [BW-1:0] data;
   } beat_t;

   beat_t sb[$];     // expected output beats, in order
   int    fw_q[$];   // expected frame lengths, in order
   int    n_checks = 0;
   int    n_fails  = 0;
   logic  fd_exp   = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word for one edge; in_valid is left high for the caller.
   task automatic drive(input logic [BW-1:0] d, input logic last, input bit accept, input int fw_len);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      if (accept) begin
         sb.push_back(beat_t'({last, d}));
         if (last) fw_q.push_back(fw_len);
      end
      tick();
   endtask

   task automatic drain(input int max_cycles, input bit rnd_ready);
      int n;
      n = 0;
      while (sb.size() != 0 && n < max_cycles) begin
         if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      check("drain_empty", 64'(sb.size()), 64'd0);
      m_axis_tready = 1'b1;
      tick();
      tick();
   endtask

   // Monitor: compares each accepted beat and the frame_done/frame_words
   // that must follow a tlast beat.
   initial begin
      beat_t exp_b;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            fd_exp = 1'b0;
         end else begin
            check("frame_done", 64'(frame_done), 64'(fd_exp));
            if (fd_exp) begin
               if (fw_q.size() == 0) check("fw_queue_has_entry", 64'(fw_q.size()), 64'd1);
               else                  check("frame_words", 64'(frame_words), 64'(fw_q.pop_front()));
            end
            fd_exp = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
               if (sb.size() == 0) begin
                  check("sb_has_entry", 64'(sb.size()), 64'd1);
               end else begin
                  exp_b = sb.pop_front();
                  $display("beat: tdata=0x%016h tlast=%0b (expected 0x%016h/%0b)",
                           m_axis_tdata, m_axis_tlast, exp_b.data, exp_b.last);
                  check("tdata", m_axis_tdata, exp_b.data);
                  check("tlast", 64'(m_axis_tlast), 64'(exp_b.last));
               end
               if (m_axis_tlast) fd_exp = 1'b1;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [BW-1:0] first_word;

      aresetn       = 1'b0;
      in_valid      = 1'b0;
      in_data       = '0;
      in_last       = 1'b0;
      m_axis_tready = 1'b0;
      tick();
      tick();

      // Reset values
      check("rst_tvalid",      64'(m_axis_tvalid), 64'd0);
      check("rst_tlast",       64'(m_axis_tlast),  64'd0);
      check("rst_tdata",       m_axis_tdata,       64'd0);
      check("rst_almost_full", 64'(almost_full),   64'd0);
      check("rst_overflow",    64'(overflow),      64'd0);
      check("rst_frame_done",  64'(frame_done),    64'd0);
      check("rst_frame_words", 64'(frame_words),   64'd0);
      aresetn = 1'b1;
      tick();

      // 1) Pass-through, 5-word frame, tready held high
      m_axis_tready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         drive(64'h1111 * 64'(i), (i == 5), 1'b1, 5);
         if (i == 1) check("t1_latency_tvalid0", 64'(m_axis_tvalid), 64'd0);
         if (i == 2) check("t1_first_tdata", m_axis_tdata, 64'h1111);
         if (i >= 2) check("t1_no_bubble", 64'(m_axis_tvalid), 64'd1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      drain(20, 1'b0);
      check("t1_frame_words", 64'(frame_words), 64'd5);

      // 2) Backpressure: 12 words held, almost_full on the 12th
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         drive(64'hB000_0000_0000_0000 + 64'(i), (i == 12), 1'b1, 12);
         if (i == 11) check("t2_af_11", 64'(almost_full), 64'd0);
         if (i == 12) check("t2_af_12", 64'(almost_full), 64'd1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
      check("t2_hold_tdata", m_axis_tdata, 64'hB000_0000_0000_0001);
      m_axis_tready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         check("t2_no_gap", 64'(m_axis_tvalid), 64'd1);
         tick();
         if (k == 0) check("t2_af_drop", 64'(almost_full), 64'd0);
      end
      check("t2_empty_after", 64'(m_axis_tvalid), 64'd0);
      drain(5, 1'b0);

      // 3) Full FIFO with simultaneous push and pop
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 16; i++) drive(64'hC300_0000_0000_0000 + 64'(i), 1'b0, 1'b1, 0);
      in_valid = 1'b0;
      tick();
      check("t3_af_full", 64'(almost_full), 64'd1);
      m_axis_tready = 1'b1;
      drive(64'hC300_0000_0000_0011, 1'b1, 1'b1, 17);
      in_valid      = 1'b0;
      in_last       = 1'b0;
      m_axis_tready = 1'b0;
      tick();
      check("t3_no_overflow", 64'(overflow), 64'd0);
      check("t3_af_still", 64'(almost_full), 64'd1);
      m_axis_tready = 1'b1;
      drain(40, 1'b0);

      // 4) Overflow: 17th word with in_last is dropped, 16th becomes tlast
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 16; i++) drive(64'hD400_0000_0000_0000 + 64'(i), 1'b0, 1'b1, 0);
      sb[sb.size() - 1].last = 1'b1;
      fw_q.push_back(16);
      drive(64'hD400_0000_0000_0011, 1'b1, 1'b0, 0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
      check("t4_overflow", 64'(overflow), 64'd1);
      first_word = 64'hD400_0000_0000_0001;
      check("t4_head", m_axis_tdata, first_word);
      m_axis_tready = 1'b1;
      drain(40, 1'b0);
      check("t4_overflow_sticky", 64'(overflow), 64'd1);

      // 5) Back-to-back frames of 3 and 2 words, random tready
      for (int i = 1; i <= 5; i++) begin
         m_axis_tready = 1'($urandom_range(0, 1));
         drive(64'hE500_0000_0000_0000 + 64'(i), (i == 3) || (i == 5), 1'b1, (i == 3) ? 3 : 2);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      drain(200, 1'b1);
      check("t5_frame_words_b", 64'(frame_words), 64'd2);

      // 6) Asynchronous reset mid-cycle with 6 words buffered
      m_axis_tready = 1'b0;
      for (int i = 1; i <= 6; i++) drive(64'hF600_0000_0000_0000 + 64'(i), 1'b0, 1'b0, 0);
      in_valid = 1'b0;
      #2;
      check("t6_tvalid_before", 64'(m_axis_tvalid), 64'd1);
      aresetn = 1'b0;
      #1;
      check("t6_tvalid_async", 64'(m_axis_tvalid), 64'd0);
      check("t6_overflow_clr", 64'(overflow), 64'd0);
      check("t6_tlast_clr", 64'(m_axis_tlast), 64'd0);
      sb.delete();
      fw_q.delete();
      tick();
      tick();
      aresetn       = 1'b1;
      m_axis_tready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t6_no_output", 64'(m_axis_tvalid), 64'd0);
      end
      drive(64'hF00D, 1'b1, 1'b1, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      drain(20, 1'b0);
      check("t6_frame_words", 64'(frame_words), 64'd1);
      check("final_fw_queue", 64'(fw_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
